// File: rtl/spi_fe.sv
// spi_fe: SPI mode-0 slave front end. It synchronises sclk/ss/mosi into clk and moves one DATA_W word each way per ss frame.
// Optional build macro SPI_MISO_TRISTATE_EN floats miso while deselected.
`ifndef DATA_W
`define DATA_W 32
`endif

module spi_fe #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                ss,
  input  logic                mosi,
  output logic                miso,
  output logic [`DATA_W-1:0]  data_out,
  input  logic [`DATA_W-1:0]  data_in,
  output logic                ss_neg_edge,
  output logic                ss_pos_edge,
  output logic                frame_err
);

  localparam int W     = `DATA_W;
  localparam int CNT_W = $clog2(W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(W + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, ss_hist_q;
  logic [W-1:0]           rx_q, rx_d, tx_q, tx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_q, neg_d, pos_q, pos_d, err_q, err_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise, active;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  // Selected on both sides of the cycle, so sclk edges coincident with an ss edge are dropped.
  assign active    = ~ss_s & ~ss_hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
    end
  end

  always_comb begin
    rx_d  = rx_q;
    tx_d  = tx_q;
    cnt_d = cnt_q;
    neg_d = ss_fall;
    pos_d = ss_rise;
    err_d = ss_rise && (cnt_q != CNT_FULL);
    if (ss_fall) begin
      tx_d  = data_in;
      cnt_d = '0;
    end else if (active) begin
      if (sclk_rise) begin
        rx_d = {rx_q[W-2:0], mosi_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      if (sclk_fall) tx_d = {tx_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q  <= '0;
      tx_q  <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      pos_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      tx_q  <= tx_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      pos_q <= pos_d;
      err_q <= err_d;
    end
  end

  assign data_out    = rx_q;
  assign ss_neg_edge = neg_q;
  assign ss_pos_edge = pos_q;
  assign frame_err   = err_q;

`ifdef SPI_MISO_TRISTATE_EN
  assign miso = ss_s ? 1'bz : tx_q[W-1];
`else
  assign miso = ss_s ? 1'b0 : tx_q[W-1];
`endif

endmodule

// File: tb/tb_spi_fe.sv
// Randomised bench for spi_fe: frame-level reference model plus per-cycle pulse/output checks.
`timescale 1ns/1ps
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_spi_fe;
  localparam int W = `DATA_W;
  localparam int S = 2;

`ifdef SPI_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sclk, ss, mosi, miso;
  logic         ss_neg_edge, ss_pos_edge, frame_err;
  logic [W-1:0] data_out, data_in;

  spi_fe #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .data_out(data_out), .data_in(data_in),
    .ss_neg_edge(ss_neg_edge), .ss_pos_edge(ss_pos_edge), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [W-1:0] d;
    logic         err;
  } pos_t;

  int           neg_q[$];
  pos_t         pos_q[$];
  logic [W-1:0] rx_m, tx_m;
  int           nbits = 0;
  int           ss_hi_cyc = 0;
  int           n_chk = 0, n_pass = 0;
  int           neg_cnt = 0, pos_cnt = 0;
  logic [W-1:0] last_d = '0, prev_d = '0;
  logic         last_err = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Per-cycle compare against the model's scheduled pulses.
  always begin
    logic e_neg, e_pos;
    pos_t p;
    @(negedge clk);
    #1;
    e_neg = (neg_q.size() > 0) && (neg_q[0] == cyc);
    if (e_neg) void'(neg_q.pop_front());
    e_pos = (pos_q.size() > 0) && (pos_q[0].c == cyc);
    p = '{0, '0, 1'b0};
    if (e_pos) p = pos_q.pop_front();
    check("ss_neg_edge", 64'(ss_neg_edge), 64'(e_neg));
    check("ss_pos_edge", 64'(ss_pos_edge), 64'(e_pos));
    check("frame_err", 64'(frame_err), 64'(e_pos ? p.err : 1'b0));
    if (e_pos) check("data_out_at_pos", 64'(data_out), 64'(p.d));
    if (ss_neg_edge) neg_cnt++;
    if (ss_pos_edge) begin
      pos_cnt++;
      prev_d   = last_d;
      last_d   = data_out;
      last_err = frame_err;
    end
    if (rst) begin
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_miso", 64'(miso), 64'(MISO_IDLE));
    end else if (ss && (cyc - ss_hi_cyc > S + 1)) begin
      check("idle_miso", 64'(miso), 64'(MISO_IDLE));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    neg_q.push_back(cyc + 1 + S);
    tx_m  = data_in;
    nbits = 0;
    tick(6);
  endtask

  task automatic send_bit(input logic b);
    logic exp;
    mosi = b;
    tick(4);
    exp = (nbits < W) ? tx_m[W-1-nbits] : 1'b0;
    check("miso_before_rise", 64'(miso), 64'(exp));
    sclk = 1'b1;
    rx_m = {rx_m[W-2:0], b};
    tick(1);
    check("miso_after_rise", 64'(miso), 64'(exp));
    tick(3);
    sclk = 1'b0;
    nbits++;
  endtask

  task automatic frame_end(input int gap);
    tick(6);
    ss = 1'b1;
    ss_hi_cyc = cyc;
    pos_q.push_back('{cyc + 1 + S, rx_m, (nbits != W)});
    tick(gap);
  endtask

  task automatic send_word(input int len, input logic [63:0] val, input int gap, input int chg_at);
    frame_start();
    for (int i = 0; i < len; i++) begin
      if (i == chg_at) data_in = '1;
      send_bit(val[len-1-i]);
    end
    frame_end(gap);
  endtask

  initial begin
    int n0;
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; data_in = '0;
    rx_m = '0; tx_m = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("reset_no_neg", 64'(neg_cnt), 64'd0);
    check("reset_no_pos", 64'(pos_cnt), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);

    // Receive
    n0 = neg_cnt;
    send_word(32, 64'hA5C3_0F81, 4, -1);
    tick(4);
    check("rx_neg_count", 64'(neg_cnt - n0), 64'd1);
    check("rx_data", 64'(last_d), 64'hA5C3_0F81);
    check("rx_err", 64'(last_err), 64'd0);

    // Transmit, data_in changed mid-frame
    data_in = 32'h8000_0001;
    send_word(32, {32'd0, $urandom}, 4, 5);
    tick(4);
    check("tx_err", 64'(last_err), 64'd0);

    // Short and long frames
    send_word(31, {33'd0, 31'(($urandom))}, 4, -1);
    tick(4);
    check("short_err", 64'(last_err), 64'd1);
    send_word(33, 64'h1_1234_5678, 4, -1);
    tick(4);
    check("long_data", 64'(last_d), 64'h1234_5678);
    check("long_err", 64'(last_err), 64'd1);

    // Back-to-back with minimum ss high gap
    n0 = pos_cnt;
    send_word(32, 64'h0000_0010, 2, -1);
    send_word(32, 64'hDEAD_BEEF, 4, -1);
    tick(4);
    check("b2b_pos_count", 64'(pos_cnt - n0), 64'd2);
    check("b2b_first", 64'(prev_d), 64'h10);
    check("b2b_second", 64'(last_d), 64'hDEAD_BEEF);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      data_in = $urandom;
      send_word(W - 1 + int'($urandom_range(0, 2)), {$urandom, $urandom},
                int'($urandom_range(2, 5)), -1);
    end
    tick(6);

    // Reset mid-frame with ss held low
    data_in = 32'h0F0F_1234;
    frame_start();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    rst = 1'b1;
    neg_q.delete();
    pos_q.delete();
    rx_m = '0;
    tx_m = '0;
    #1;
    check("midrst_data_out", 64'(data_out), 64'd0);
    check("midrst_neg", 64'(ss_neg_edge), 64'd0);
    tick(3);
    n0 = neg_cnt;
    rst = 1'b0;
    neg_q.push_back(cyc + 1 + S);
    tx_m  = data_in;
    nbits = 0;
    tick(4);
    check("midrst_neg_after_release", 64'(neg_cnt - n0), 64'd1);
    tick(2);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    frame_end(4);
    tick(4);
    check("midrst_err", 64'(last_err), 64'd1);

    tick(10);
    check("pending_pulses", 64'(neg_q.size() + pos_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_fe.md
# spi_fe

SPI slave front end feeding `spi_protocol`. It synchronises the external `sclk`, `ss` and `mosi` pins into the `clk` domain and deserialises one `DATA_W`-bit word per slave-select frame. It emits one-cycle select-edge pulses and serialises the read-back word on `miso` in SPI mode 0. Its outputs drive `spi_protocol`'s `data_fe_in`, `ss_pos_edge` and `ss_neg_edge`; its `data_in` is driven by `spi_protocol`'s `data_fe_out`.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `ss`, `mosi`; minimum 2.
- `DATA_W`, `ADDR_W`: taken from `spi-defines.v`; not parameters.

Ports:
- `clk`  in  1  system clock, only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `sclk`  in  1  SPI clock pin, asynchronous to `clk`, idles low.
- `ss`  in  1  slave select pin, active-low, asynchronous.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `data_out`  out  `DATA_W`  received word; this is the rx shift register, frozen while deselected.
- `data_in`  in  `DATA_W`  word to transmit in the next frame.
- `ss_neg_edge`  out  1  one-cycle pulse: frame start.
- `ss_pos_edge`  out  1  one-cycle pulse: frame end; `data_out` is valid in this cycle.
- `frame_err`  out  1  one-cycle pulse coincident with `ss_pos_edge` when the bit count is not equal to `DATA_W`.

## Operation
- **Synchronisers.**
  - Each pin passes through `SYNC_STAGES` flops, then one history flop.
  - Reset values model the idle bus: `sclk`=0, `ss`=1, `mosi`=0.
  - Edge detect compares the last sync stage with the history flop.
- **Selected state.** The block is selected while synchronised `ss` = 0.
- **Frame start** (synchronised `ss` 1→0):
  - `ss_neg_edge` <= 1.
  - tx shift register <= `data_in`.
  - bit counter <= 0.
- **`sclk` rise while selected:**
  - rx <= {rx[`DATA_W`-2:0], mosi_sync}.
  - Counter increments and saturates at `DATA_W`+1.
- **`sclk` fall while selected:** tx <= {tx[`DATA_W`-2:0], 1'b0}.
- **Extra bits.** Beyond `DATA_W` bits, shifting continues, so rx holds the last `DATA_W` bits.
- **Frame end** (synchronised `ss` 0→1):
  - `ss_pos_edge` <= 1.
  - `frame_err` <= (counter != `DATA_W`).
- **Deselected.** rx and tx are not modified, and `sclk` edges are ignored.
- **Simultaneous events.**
  - An `sclk` edge detected in the same cycle as the `ss` rise is discarded.
  - An `sclk` edge in the same cycle as the `ss` fall is discarded.
- **`miso` output.** Driven from tx[`DATA_W`-1] while selected; see Configuration for the deselected value.
- **Reset values.** `data_out`=0, tx=0, counter=0, `ss_pos_edge`=0, `ss_neg_edge`=0, `frame_err`=0, `miso` per Configuration.
- **Reset mid-frame.**
  - All state reinitialises.
  - If the `ss` pin is still low after reset, the synchroniser reports a fresh `ss` fall, so `ss_neg_edge` fires.
  - The truncated frame ends with `frame_err`=1.

## Timing
- **Pulse outputs.** `ss_neg_edge`, `ss_pos_edge` and `frame_err` are registered, exactly 1 cycle wide.
- **Pin-to-pulse latency.** A pin transition sampled at `clk` edge N produces its pulse high in the cycle after edge N+`SYNC_STAGES`. With the default depth this is 3 cycles.
- **`data_out` stability.** Stable from the last `sclk` rise + `SYNC_STAGES`+1 cycles until the next frame's first `sclk` rise. It is therefore valid throughout the `ss_pos_edge` cycle.
- **`data_in` capture.** Sampled only in the cycle the `ss` fall is detected.
- **First `miso` bit.** Valid `SYNC_STAGES`+1 cycles after the `ss` pin falls.
- **Host constraints** for correct operation:
  - f(`clk`) ≥ 8·f(`sclk`).
  - `ss`-fall to first `sclk` rise ≥ (`SYNC_STAGES`+2) `clk` periods.
  - Last `sclk` fall to `ss` rise ≥ (`SYNC_STAGES`+2) periods.

## Configuration
- **`SPI_MISO_TRISTATE_EN` defined:** `miso` = 1'bz whenever synchronised `ss` = 1, including during reset. Use this for shared-bus slaves.
- **`SPI_MISO_TRISTATE_EN` not defined:** `miso` = 1'b0 whenever deselected and during reset. `miso` is never Z.
- **Both builds:** identical selected-state behaviour and timing.

## Test plan
- Reset with pins idle, DATA_W=32 → all outputs 0 (`miso` Z with macro); no pulses for 10 cycles after release.
- **Receive:** frame of 32 bits 0xA5C3_0F81, `clk`=8·`sclk` → one `ss_neg_edge`; `data_out`=0xA5C30F81 in the `ss_pos_edge` cycle; `frame_err`=0.
- **Transmit:** `data_in`=0x8000_0001 held before `ss` falls → `miso` bits are 1, thirty 0s, then 1, each stable across its `sclk` rise; `data_in` changed mid-frame to 0xFFFFFFFF has no effect.
- **Short and long frames:**
  - 31-bit frame → `frame_err`=1 with `ss_pos_edge`.
  - 33-bit frame sending 0x1 then 0x12345678 → `data_out`=0x12345678, `frame_err`=1.
- **Back-to-back frames:** address word 0x0000_0010 then data word 0xDEADBEEF, minimum `ss` high gap → two clean pulse pairs; `data_out` sequence 0x10, 0xDEADBEEF.
- **Reset mid-frame:** assert `rst` after 12 bits while `ss` stays low → outputs return to reset values; after release, `ss_neg_edge` fires within 3 cycles; the frame ends with `frame_err`=1.
